chimera_cfg_strap_sel: RTL and testbench
========================================

# chimera_cfg_strap_sel

Runtime configuration selector for Chimera SoC-level settings. It resolves one of `NumCfgs` compile-time configuration words from asynchronous strap pins after reset: the pins are synchronised and debounced, and an out-of-range index falls back to a default entry. After resolution, software may switch or re-latch the configuration through a req/gnt handshake, and a lock input freezes it. It sits between the pad straps and the configuration consumers (boot logic, cluster config registers) and replaces fixed, index-parameter-only config selection.

## Interface
- `NumCfgs`, 4: number of table entries; must be ≥ 2.
- `CfgWidth`, 32: width of one configuration word.
- `CfgTable`, '0: packed `NumCfgs*CfgWidth` bits; entry k at `[k*CfgWidth +: CfgWidth]`.
- `StableCycles`, 16: number of consecutive identical synchronised samples required; must be ≥ 1.
- `DefaultIdx`, 0: fallback and reset index; must be < `NumCfgs`.
- Derived: `IdxW = max(1, $clog2(NumCfgs))`.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `sel_pins_i` in IdxW: asynchronous strap pins.
- `relatch_i` in 1: restart strap sampling; level, sampled each cycle.
- `lock_i` in 1: freezes the active config; rejects switch and relatch.
- `sw_req_i` in 1: software switch request.
- `sw_idx_i` in IdxW: requested index; must be stable while `sw_req_i` is high.
- `sw_gnt_o` out 1: one-cycle request completion pulse.
- `sw_err_o` out 1: one-cycle pulse flagging a rejected request or an out-of-range strap.
- `cfg_o` out CfgWidth: selected configuration word (registered).
- `cfg_idx_o` out IdxW: selected index (registered).
- `cfg_valid_o` out 1: high while `cfg_o` is resolved.

## Operation
- Reset values: `cfg_idx_o`=DefaultIdx, `cfg_o`=entry DefaultIdx, `cfg_valid_o`=0, `sw_gnt_o`=0, `sw_err_o`=0. The FSM resets to SYNC, the counter to 0, and the sync flops to 0.
- Synchroniser: 2-flop on `sel_pins_i`. The debounce logic uses only the second-stage output `s`.
- FSM states:
  - SYNC: 2 cycles to flush the synchroniser, then go to SAMPLE with cnt=0.
  - SAMPLE: if cnt==0 or `s`==cand, then cand=`s` and cnt++. Otherwise cand=`s` and cnt=1. When cnt reaches StableCycles, go to ACTIVE and register idx=cand, or DefaultIdx if cand ≥ NumCfgs. The out-of-range case also pulses `sw_err_o`.
  - ACTIVE: `cfg_valid_o`=1.
    - `relatch_i`=1 and `lock_i`=0: go to SAMPLE with cnt=0. `cfg_valid_o` drops on the next edge. `cfg_o`/`cfg_idx_o` hold their last value.
    - `relatch_i` and `lock_i` both high: ignored, no error pulse.
- Software handshake:
  - A request is accepted only in a cycle where `sw_req_i`=1 and `sw_gnt_o`=0. Every accepted request produces `sw_gnt_o`=1 on the next cycle.
  - A held request therefore yields a grant every other cycle.
  - Success requires state ACTIVE, `lock_i`=0, `sw_idx_i` < NumCfgs, and no `relatch_i` in the same cycle. On success, `cfg_idx_o`/`cfg_o` update on the same edge as `sw_gnt_o` rises, with `cfg_valid_o` held at 1 (no glitch).
  - Any other outcome grants with `sw_err_o`=1 and leaves the outputs unchanged.
- `cfg_o` always equals `CfgTable[cfg_idx_o]`. Both are registered together, never combinationally.
- `lock_i` has no effect on the reset-time resolution.
- Reset asserted mid-operation returns everything to the reset values asynchronously. Sampling restarts at SYNC.

## Timing
- Resolution latency with pins stable: `cfg_valid_o` rises at edge 2+StableCycles, counting the first rising edge after `rst_ni` deasserts as edge 1. With default parameters this is edge 18.
- A pin change during SAMPLE restarts the StableCycles window. Latency becomes 2+StableCycles edges after the last change, counted as in the previous item.
- Relatch latency: `cfg_valid_o` is 0 one edge after `relatch_i`, and valid again StableCycles edges after that. There is no SYNC re-entry, since the synchroniser stays running.
- Software switch latency: 1 cycle from request acceptance to `sw_gnt_o` and the new `cfg_o`.
- `sw_err_o` is coincident with `sw_gnt_o` for requests. For an out-of-range strap it is coincident with the `cfg_valid_o` rising edge.

## Test plan
- Pins=2 stable through reset, NumCfgs=4, StableCycles=16 → `cfg_valid_o` rises at edge 18, `cfg_idx_o`=2, `cfg_o`=entry 2, no `sw_err_o`.
- Pins toggle 1→3 at edge 10 then stay → valid at edge 10+2+16 (±1 for synchroniser phase), `cfg_idx_o`=3; `cfg_valid_o` stays 0 before that.
- NumCfgs=3, pins=3 → idx=DefaultIdx=0, `sw_err_o` pulses once together with the `cfg_valid_o` rise.
- ACTIVE with idx=0, then `sw_req_i`=1 with `sw_idx_i`=1, held high → gnt the next cycle with idx=1 and no valid glitch. Then, with `lock_i`=1, request idx 2 → gnt+err, idx stays 1.
- `relatch_i` and `sw_req_i` in the same cycle, unlocked → gnt+err, `cfg_valid_o` drops the next cycle, then re-resolves from the pins after 16 cycles.
- Assert `rst_ni` mid-SAMPLE and mid-grant → all outputs at reset values immediately; full resolution sequence repeats after release.

Source files
------------

// File: rtl/chimera_cfg_strap_sel_if.sv
`default_nettype none
// ============================================================================
// Module   : chimera_cfg_strap_sel_if
// Brief    : Strap, software handshake and configuration bus for the
//            Chimera configuration selector.
// Revision : 1.0 - initial release
// ============================================================================
interface chimera_cfg_strap_sel_if #(
    parameter int unsigned IdxW     = 2,
    parameter int unsigned CfgWidth = 32
);
    logic [IdxW-1:0]     sel_pins_i;
    logic                relatch_i;
    logic                lock_i;
    logic                sw_req_i;
    logic [IdxW-1:0]     sw_idx_i;
    logic                sw_gnt_o;
    logic                sw_err_o;
    logic [CfgWidth-1:0] cfg_o;
    logic [IdxW-1:0]     cfg_idx_o;
    logic                cfg_valid_o;

    modport master (
        output sel_pins_i, relatch_i, lock_i, sw_req_i, sw_idx_i,
        input  sw_gnt_o, sw_err_o, cfg_o, cfg_idx_o, cfg_valid_o
    );

    modport slave (
        input  sel_pins_i, relatch_i, lock_i, sw_req_i, sw_idx_i,
        output sw_gnt_o, sw_err_o, cfg_o, cfg_idx_o, cfg_valid_o
    );
endinterface
`default_nettype wire

// File: rtl/chimera_cfg_strap_sel.sv
`default_nettype none
// ============================================================================
// Module   : chimera_cfg_strap_sel
// Brief    : Resolves a configuration word from debounced strap pins, with
//            software switch/relatch handshake and lock.
// Revision : 1.0 - initial release
// ============================================================================
module chimera_cfg_strap_sel #(
    parameter int unsigned                     NumCfgs      = 4,
    parameter int unsigned                     CfgWidth     = 32,
    parameter logic [NumCfgs*CfgWidth-1:0]     CfgTable     = '0,
    parameter int unsigned                     StableCycles = 16,
    parameter int unsigned                     DefaultIdx   = 0
) (
    input  wire logic               clk_i,
    input  wire logic               rst_ni,
    chimera_cfg_strap_sel_if.slave  bus
);

    localparam int unsigned IdxW    = (NumCfgs > 2) ? $clog2(NumCfgs) : 1;
    localparam int unsigned c_cnt_w = (StableCycles > 1) ? $clog2(StableCycles + 1) : 1;

    localparam logic [c_cnt_w-1:0]  c_cnt_one     = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_done    = c_cnt_w'(StableCycles);
    localparam logic [IdxW:0]       c_num_cfgs    = (IdxW+1)'(NumCfgs);
    localparam logic [IdxW-1:0]     c_def_idx     = IdxW'(DefaultIdx);
    localparam logic [CfgWidth-1:0] c_default_cfg = CfgTable[DefaultIdx*CfgWidth +: CfgWidth];

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_ACTIVE = 2'd2
    } state_e;

    state_e              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [IdxW-1:0]     r_sync1, r_sync2;
    logic [IdxW-1:0]     r_cand, w_cand_nxt;
    logic [IdxW-1:0]     r_idx, w_idx_nxt;
    logic [CfgWidth-1:0] r_cfg, w_cfg_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_gnt, w_gnt_nxt;
    logic                r_err, w_err_nxt;

    logic w_accept;
    logic w_sw_ok;
    logic w_cand_in_range;
    logic w_sw_in_range;

    // A held request is only re-accepted once its previous grant has retired.
    assign w_accept        = bus.sw_req_i & ~r_gnt;
    assign w_sw_in_range   = ({1'b0, bus.sw_idx_i} < c_num_cfgs);
    assign w_cand_in_range = ({1'b0, r_sync2} < c_num_cfgs);
    assign w_sw_ok         = (r_state == ST_ACTIVE) & ~bus.lock_i & ~bus.relatch_i & w_sw_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_SYNC;
            r_cnt   <= '0;
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_cand  <= '0;
            r_idx   <= c_def_idx;
            r_cfg   <= c_default_cfg;
            r_valid <= 1'b0;
            r_gnt   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_sync1 <= bus.sel_pins_i;
            r_sync2 <= r_sync1;
            r_cand  <= w_cand_nxt;
            r_idx   <= w_idx_nxt;
            r_cfg   <= w_cfg_nxt;
            r_valid <= w_valid_nxt;
            r_gnt   <= w_gnt_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cand_nxt  = r_cand;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_gnt_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_cfg_nxt   = c_default_cfg;

        case (r_state)
            ST_SYNC: begin
                if (r_cnt == c_cnt_one) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end
            end
            ST_SAMPLE: begin
                w_cand_nxt = r_sync2;
                if ((r_cnt == '0) || (r_sync2 == r_cand)) begin
                    w_cnt_nxt = r_cnt + c_cnt_one;
                end else begin
                    w_cnt_nxt = c_cnt_one;
                end
                if (w_cnt_nxt == c_cnt_done) begin
                    w_state_nxt = ST_ACTIVE;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    if (w_cand_in_range) begin
                        w_idx_nxt = r_sync2;
                    end else begin
                        w_idx_nxt = c_def_idx;
                        w_err_nxt = 1'b1;
                    end
                end
            end
            ST_ACTIVE: begin
                if (bus.relatch_i && !bus.lock_i) begin
                    w_state_nxt = ST_SAMPLE;
                    w_cnt_nxt   = '0;
                    w_valid_nxt = 1'b0;
                end else if (w_accept && w_sw_ok) begin
                    w_idx_nxt = bus.sw_idx_i;
                end
            end
            default: begin
                w_state_nxt = ST_SYNC;
                w_cnt_nxt   = '0;
                w_valid_nxt = 1'b0;
            end
        endcase

        if (w_accept) begin
            w_gnt_nxt = 1'b1;
            if (!w_sw_ok) begin
                w_err_nxt = 1'b1;
            end
        end

        // Config word follows the next index so both register on the same edge.
        for (int k = 0; k < int'(NumCfgs); k++) begin
            if (w_idx_nxt == IdxW'(k)) begin
                w_cfg_nxt = CfgTable[k*CfgWidth +: CfgWidth];
            end
        end
    end

    assign bus.cfg_o       = r_cfg;
    assign bus.cfg_idx_o   = r_idx;
    assign bus.cfg_valid_o = r_valid;
    assign bus.sw_gnt_o    = r_gnt;
    assign bus.sw_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_chimera_cfg_strap_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_chimera_cfg_strap_sel
// Brief    : Two selector instances (4 and 3 entries) driven with shared
//            directed and random stimulus, checked against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chimera_cfg_strap_sel;

    localparam int unsigned STABLE = 16;
    localparam logic [127:0] TBL_A = {32'hDDDD0003, 32'hCCCC0002, 32'hBBBB0001, 32'hAAAA0000};
    localparam logic [95:0]  TBL_B = {32'h33330002, 32'h22220001, 32'h11110000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] pins = 2'd2;
    logic       relatch = 1'b0;
    logic       lock = 1'b0;
    logic       req = 1'b0;
    logic [1:0] sidx = 2'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    chimera_cfg_strap_sel_if #(.IdxW(2), .CfgWidth(32)) ifa ();
    chimera_cfg_strap_sel_if #(.IdxW(2), .CfgWidth(32)) ifb ();

    assign ifa.sel_pins_i = pins;
    assign ifa.relatch_i  = relatch;
    assign ifa.lock_i     = lock;
    assign ifa.sw_req_i   = req;
    assign ifa.sw_idx_i   = sidx;
    assign ifb.sel_pins_i = pins;
    assign ifb.relatch_i  = relatch;
    assign ifb.lock_i     = lock;
    assign ifb.sw_req_i   = req;
    assign ifb.sw_idx_i   = sidx;

    chimera_cfg_strap_sel #(
        .NumCfgs(4), .CfgWidth(32), .CfgTable(TBL_A), .StableCycles(STABLE), .DefaultIdx(0)
    ) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa.slave));

    chimera_cfg_strap_sel #(
        .NumCfgs(3), .CfgWidth(32), .CfgTable(TBL_B), .StableCycles(STABLE), .DefaultIdx(0)
    ) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb.slave));

    // Reference model state, one slot per instance.
    int unsigned ncfg [2] = '{4, 3};
    int          m_edge [2];
    int unsigned m_s1 [2];
    int unsigned m_s2 [2];
    bit          m_active [2];
    int          m_win [2];
    int          m_run_len [2];
    int unsigned m_run_val [2];
    int unsigned m_idx [2];
    bit          m_valid [2];
    bit          m_gnt [2];
    bit          m_err [2];

    function automatic logic [31:0] table_word(int inst, int unsigned idx);
        logic [127:0] ta;
        logic [95:0]  tb;
        ta = TBL_A;
        tb = TBL_B;
        if (inst == 0) return ta[idx*32 +: 32];
        return tb[idx*32 +: 32];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_edge[i] = 0; m_s1[i] = 0; m_s2[i] = 0; m_active[i] = 0;
            m_win[i] = 3; m_run_len[i] = 0; m_run_val[i] = 0;
            m_idx[i] = 0; m_valid[i] = 0; m_gnt[i] = 0; m_err[i] = 0;
        end
    endtask

    // Predicts the outputs after the coming rising edge from the inputs now applied.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int          n;
            bit          acc;
            bit          ok;
            int unsigned s;
            n   = m_edge[i] + 1;
            s   = m_s2[i];
            acc = req && !m_gnt[i];
            ok  = m_active[i] && !lock && (int'(sidx) < int'(ncfg[i])) && !relatch;
            m_err[i] = 0;
            if (m_active[i]) begin
                if (relatch && !lock) begin
                    m_active[i] = 0;
                    m_valid[i]  = 0;
                    m_win[i]    = n + 1;
                end else if (acc && ok) begin
                    m_idx[i] = sidx;
                end
            end else if (n >= m_win[i]) begin
                if (n == m_win[i] || s != m_run_val[i]) begin
                    m_run_val[i] = s;
                    m_run_len[i] = 1;
                end else begin
                    m_run_len[i]++;
                end
                if (m_run_len[i] == int'(STABLE)) begin
                    m_active[i] = 1;
                    m_valid[i]  = 1;
                    if (s < ncfg[i]) m_idx[i] = s;
                    else begin
                        m_idx[i] = 0;
                        m_err[i] = 1;
                    end
                end
            end
            m_gnt[i] = acc;
            if (acc && !ok) m_err[i] = 1;
            m_s2[i]   = m_s1[i];
            m_s1[i]   = pins;
            m_edge[i] = n;
        end
    endtask

    task automatic check_all();
        chk("a_valid", 32'(ifa.cfg_valid_o), 32'(m_valid[0]));
        chk("a_idx",   32'(ifa.cfg_idx_o),   m_idx[0]);
        chk("a_cfg",   ifa.cfg_o,            table_word(0, m_idx[0]));
        chk("a_gnt",   32'(ifa.sw_gnt_o),    32'(m_gnt[0]));
        chk("a_err",   32'(ifa.sw_err_o),    32'(m_err[0]));
        chk("b_valid", 32'(ifb.cfg_valid_o), 32'(m_valid[1]));
        chk("b_idx",   32'(ifb.cfg_idx_o),   m_idx[1]);
        chk("b_cfg",   ifb.cfg_o,            table_word(1, m_idx[1]));
        chk("b_gnt",   32'(ifb.sw_gnt_o),    32'(m_gnt[1]));
        chk("b_err",   32'(ifb.sw_err_o),    32'(m_err[1]));
    endtask

    // Called at a negedge with inputs applied; returns at the following negedge.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n   = 1'b0;
        relatch = 1'b0;
        req     = 1'b0;
        model_reset();
        #1;
        chk("rst_a_valid", 32'(ifa.cfg_valid_o), 32'd0);
        chk("rst_a_idx",   32'(ifa.cfg_idx_o),   32'd0);
        chk("rst_a_cfg",   ifa.cfg_o,            32'hAAAA0000);
        chk("rst_a_gnt",   32'(ifa.sw_gnt_o),    32'd0);
        chk("rst_b_cfg",   ifb.cfg_o,            32'h11110000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_valid_a(output int n);
        n = 0;
        while (!ifa.cfg_valid_o && n < 60) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        int n;
        int berr;

        // Power-on resolution with pins stable at 2.
        @(negedge clk);
        pins = 2'd2;
        reset_pulse();
        wait_valid_a(n);
        chk("res_edge", 32'(n), 32'd18);
        chk("res_idx",  32'(ifa.cfg_idx_o), 32'd2);
        chk("res_cfg",  ifa.cfg_o, 32'hCCCC0002);
        chk("res_err",  32'(ifa.sw_err_o), 32'd0);

        // Pin change after edge 10 restarts the window; B falls back to entry 0.
        pins = 2'd1;
        reset_pulse();
        repeat (10) cycle();
        pins = 2'd3;
        berr = 0;
        n = 10;
        while (!ifa.cfg_valid_o && n < 60) begin
            cycle();
            n++;
            if (ifb.sw_err_o) berr++;
        end
        chk("chg_edge",  32'(n), 32'd28);
        chk("chg_idx",   32'(ifa.cfg_idx_o), 32'd3);
        chk("chg_cfg",   ifa.cfg_o, 32'hDDDD0003);
        chk("oor_idx",   32'(ifb.cfg_idx_o), 32'd0);
        chk("oor_err",   32'(ifb.sw_err_o), 32'd1);
        chk("oor_count", 32'(berr), 32'd1);

        // Held software switch to entry 1.
        req = 1'b1; sidx = 2'd1;
        cycle();
        chk("sw_gnt",   32'(ifa.sw_gnt_o), 32'd1);
        chk("sw_idx",   32'(ifa.cfg_idx_o), 32'd1);
        chk("sw_cfg",   ifa.cfg_o, 32'hBBBB0001);
        chk("sw_valid", 32'(ifa.cfg_valid_o), 32'd1);
        cycle();
        chk("sw_hold_gap", 32'(ifa.sw_gnt_o), 32'd0);
        cycle();
        chk("sw_hold_gnt", 32'(ifa.sw_gnt_o), 32'd1);
        req = 1'b0;
        cycle();

        // Locked switch is rejected.
        lock = 1'b1; req = 1'b1; sidx = 2'd2;
        cycle();
        chk("lock_gnt", 32'(ifa.sw_gnt_o), 32'd1);
        chk("lock_err", 32'(ifa.sw_err_o), 32'd1);
        chk("lock_idx", 32'(ifa.cfg_idx_o), 32'd1);
        req = 1'b0;
        cycle();
        lock = 1'b0;
        cycle();

        // Relatch together with a request.
        relatch = 1'b1; req = 1'b1; sidx = 2'd2;
        cycle();
        chk("rl_gnt",   32'(ifa.sw_gnt_o), 32'd1);
        chk("rl_err",   32'(ifa.sw_err_o), 32'd1);
        chk("rl_valid", 32'(ifa.cfg_valid_o), 32'd0);
        chk("rl_hold",  32'(ifa.cfg_idx_o), 32'd1);
        relatch = 1'b0; req = 1'b0;
        wait_valid_a(n);
        chk("rl_cycles", 32'(n), 32'd16);
        chk("rl_idx",    32'(ifa.cfg_idx_o), 32'd3);

        // Reset during a grant, then during sampling.
        req = 1'b1; sidx = 2'd0;
        cycle();
        chk("mid_gnt", 32'(ifa.sw_gnt_o), 32'd1);
        reset_pulse();
        repeat (8) cycle();
        reset_pulse();
        wait_valid_a(n);
        chk("rerun_edge", 32'(n), 32'd18);

        // Randomised traffic.
        for (int c = 0; c < 4000; c++) begin
            bit nreq;
            if ($urandom_range(0, 39) == 0) pins = 2'($urandom);
            relatch = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) lock = ~lock;
            nreq = ($urandom_range(0, 2) == 0);
            if (!(req && nreq)) sidx = 2'($urandom);
            req = nreq;
            if ($urandom_range(0, 799) == 0) begin
                reset_pulse();
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
